// File: rtl/fpu_writeback_stage.sv
// FPU writeback stage: runs the exec element one op at a time and queues its results
// for the FP register-file write port. Optional combinational bypass: FPU_WB_BYPASS_EN.
module fpu_writeback_stage #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [REG_W-1:0]  issue_fd,
  output logic              issue_ready,
  output logic              elem_reset,
  input  logic              elem_completed,
  input  logic [DATA_W-1:0] elem_out,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_fd,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ready,
  output logic              busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [REG_W-1:0]  fd;
    logic [DATA_W-1:0] data;
  } wb_ent_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [REG_W-1:0] pend_fd;
  wb_ent_t          mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  wb_ent_t          hold;
  wb_ent_t          head;
  logic             fifo_nempty, done, byp, push, pop, accept;

  assign fifo_nempty = (count != '0);
  assign done        = (state == RUN) && elem_completed;

`ifdef FPU_WB_BYPASS_EN
  assign byp = done && !fifo_nempty;
`else
  assign byp = 1'b0;
`endif

  // Gated by reset so the dispatcher sees no acceptance while the stage is held.
  assign issue_ready = reset && (state == IDLE) && (count < CW'(DEPTH));
  assign accept      = issue_valid && issue_ready;
  assign elem_reset  = (state != RUN);
  assign busy        = (state == RUN) || fifo_nempty;

  always_comb begin
    head = hold;
    if (byp)              head = '{fd: pend_fd, data: elem_out};
    else if (fifo_nempty) head = mem[rd_ptr];
  end

  assign wb_valid = fifo_nempty || byp;
  assign wb_fd    = head.fd;
  assign wb_data  = head.data;

  // A bypassed result that is taken immediately never occupies a slot.
  assign push = done && !(byp && wb_ready);
  assign pop  = fifo_nempty && wb_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pend_fd <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          pend_fd <= issue_fd;
          state   <= RUN;
        end
        RUN: if (elem_completed) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{fd: pend_fd, data: elem_out};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // Keeps the write-port outputs stable at the last value once the queue drains.
      if (wb_valid && wb_ready) hold <= head;
    end
  end
endmodule

// File: tb/tb_fpu_writeback_stage.sv
// Self-checking bench for fpu_writeback_stage: scoreboard of written results plus
// a vector table and directed multi-cycle sequences.
module tb_fpu_writeback_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready, elem_reset, elem_completed;
  logic [4:0]  issue_fd, wb_fd;
  logic [31:0] elem_out, wb_data, elem_data;
  logic        wb_valid, wb_ready, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  fd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [4:0]  fd;
    logic [31:0] data;
    int          lat;
    int          exp_k;
  } vec_t;

  fpu_writeback_stage #(.DEPTH(2), .DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_fd(issue_fd),
    .issue_ready(issue_ready), .elem_reset(elem_reset), .elem_completed(elem_completed),
    .elem_out(elem_out), .wb_valid(wb_valid), .wb_fd(wb_fd), .wb_data(wb_data),
    .wb_ready(wb_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Element model: completed rises lat edges after its reset is released
  // (lat=1 is the one-cycle element; lat=3 makes completed visible in the 4th RUN cycle).
  int lat_cfg = 1;
  int ecnt;
  always @(posedge clk) begin
    if (elem_reset) begin
      ecnt           <= 0;
      elem_completed <= 1'b0;
    end else if (!elem_completed) begin
      ecnt <= ecnt + 1;
      if (ecnt + 1 == lat_cfg) elem_completed <= 1'b1;
    end
  end
  assign elem_out = elem_data;

  // Scoreboard: every handshake on the write port must match the oldest accepted op.
  always @(negedge clk) begin
    #3;
    if (reset && wb_valid && wb_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got fd=%0d data=%h with no op outstanding", wb_fd, wb_data);
      end else begin
        automatic exp_t e = exp_q.pop_front();
        if (wb_fd !== e.fd || wb_data !== e.data) begin
          errors++;
          $display("FAIL wb_order got fd=%0d data=%h want fd=%0d data=%h", wb_fd, wb_data, e.fd, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [4:0] fd, input logic [31:0] data, input int lat);
    int i;
    issue_valid = 1'b0;
    for (i = 0; i < 50 && !issue_ready; i++) step();
    if (!issue_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout fd=%0d got issue_ready=0 want 1", fd);
    end
    lat_cfg     = lat;
    elem_data   = data;
    issue_fd    = fd;
    issue_valid = 1'b1;
    exp_q.push_back('{fd: fd, data: data});
    step();
    issue_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 100 && (busy || exp_q.size() != 0); i++) step();
    chk("drain_done", {31'd0, busy || exp_q.size() != 0}, 32'd0);
  endtask

  vec_t vecs[5];
  int   byp_adj;

  initial begin
`ifdef FPU_WB_BYPASS_EN
    byp_adj = 1;
`else
    byp_adj = 0;
`endif
    vecs[0] = '{fd: 5'd0,  data: 32'h0000_0000, lat: 1, exp_k: 2};
    vecs[1] = '{fd: 5'd31, data: 32'hFFFF_FFFF, lat: 1, exp_k: 2};
    vecs[2] = '{fd: 5'd9,  data: 32'hC049_0FDB, lat: 2, exp_k: 3};
    vecs[3] = '{fd: 5'd16, data: 32'h7F80_0000, lat: 3, exp_k: 4};
    vecs[4] = '{fd: 5'd21, data: 32'hA5A5_5A5A, lat: 5, exp_k: 6};

    reset = 1'b0; issue_valid = 1'b0; issue_fd = '0; wb_ready = 1'b1; elem_data = '0;

    // Reset state
    repeat (3) step();
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd0);
    chk("rst_elem_reset",  {31'd0, elem_reset},  32'd1);
    chk("rst_wb_valid",    {31'd0, wb_valid},    32'd0);
    chk("rst_wb_fd",       {27'd0, wb_fd},       32'd0);
    chk("rst_wb_data",     wb_data,              32'd0);
    chk("rst_busy",        {31'd0, busy},        32'd0);
    reset = 1'b1;
    step();
    chk("post_rst_elem_reset",  {31'd0, elem_reset},  32'd1);
    chk("post_rst_wb_valid",    {31'd0, wb_valid},    32'd0);
    chk("post_rst_busy",        {31'd0, busy},        32'd0);
    chk("post_rst_issue_ready", {31'd0, issue_ready}, 32'd1);

    // Single op, one-cycle element, fd=7
    do_issue(5'd7, 32'h3F80_0000, 1);
    chk("lat_run_elem_reset", {31'd0, elem_reset}, 32'd0);
    chk("lat_run_busy",       {31'd0, busy},       32'd1);
    chk("lat_n0_wb_valid",    {31'd0, wb_valid},   32'd0);
    step();
`ifdef FPU_WB_BYPASS_EN
    chk("byp_n1_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("byp_n1_wb_fd",    {27'd0, wb_fd},    32'd7);
    chk("byp_n1_wb_data",  wb_data,           32'h3F80_0000);
    step();
    chk("byp_n2_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("byp_n2_busy",     {31'd0, busy},     32'd0);
`else
    chk("lat_n1_wb_valid", {31'd0, wb_valid}, 32'd0);
    step();
    chk("lat_n2_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("lat_n2_wb_fd",    {27'd0, wb_fd},    32'd7);
    chk("lat_n2_wb_data",  wb_data,           32'h3F80_0000);
    step();
    chk("lat_n3_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("lat_n3_busy",     {31'd0, busy},     32'd0);
    chk("lat_hold_wb_fd",  {27'd0, wb_fd},    32'd7);
`endif
    wait_idle();

    // Table: one op at a time, latency to first wb_valid and head contents
    foreach (vecs[v]) begin
      int k;
      do_issue(vecs[v].fd, vecs[v].data, vecs[v].lat);
      k = 0;
      while (k < 40 && !wb_valid) begin step(); k++; end
      chk($sformatf("vec%0d_latency", v), k, vecs[v].exp_k - byp_adj);
      chk($sformatf("vec%0d_fd", v),      {27'd0, wb_fd}, {27'd0, vecs[v].fd});
      chk($sformatf("vec%0d_data", v),    wb_data, vecs[v].data);
      wait_idle();
    end

    // FIFO fill with write port stalled, third op held off, in-order drain
    wb_ready = 1'b0;
    do_issue(5'd1, 32'h1111_1111, 1);
    do_issue(5'd2, 32'h2222_2222, 1);
    repeat (2) step();
    elem_data   = 32'h3333_3333;
    issue_fd    = 5'd3;
    issue_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("full_issue_ready%0d", c), {31'd0, issue_ready}, 32'd0);
      chk($sformatf("full_elem_reset%0d", c),  {31'd0, elem_reset},  32'd1);
      chk($sformatf("full_head_fd%0d", c),     {27'd0, wb_fd},       32'd1);
      step();
    end
    chk("full_head_data", wb_data, 32'h1111_1111);
    wb_ready = 1'b1;
    begin
      int c;
      for (c = 0; c < 10 && !issue_ready; c++) step();
      chk("full_third_accept", {31'd0, issue_ready}, 32'd1);
      exp_q.push_back('{fd: 5'd3, data: 32'h3333_3333});
      step();
      issue_valid = 1'b0;
    end
    wait_idle();

    // Slow element: RUN lasts 4 cycles, then at least one elem_reset=1 cycle before the next RUN
    begin
      int low;
      do_issue(5'd4, 32'h4444_4444, 3);
      issue_fd    = 5'd5;
      issue_valid = 1'b1;
      low = 1;
      for (int c = 0; c < 20; c++) begin
        step();
        if (elem_reset) break;
        low++;
      end
      chk("slow_run_cycles", low, 4);
      chk("slow_gap_issue_ready", {31'd0, issue_ready}, 32'd1);
      exp_q.push_back('{fd: 5'd5, data: 32'h4444_4444});
      step();
      issue_valid = 1'b0;
      chk("slow_next_run", {31'd0, elem_reset}, 32'd0);
      wait_idle();
    end

    // Reset pulled between edges while in RUN with one queued entry
    wb_ready = 1'b0;
    do_issue(5'd10, 32'hAAAA_0001, 1);
    repeat (2) step();
    chk("mid_queued", {31'd0, wb_valid}, 32'd1);
    do_issue(5'd11, 32'hBBBB_0002, 5);
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_elem_reset", {31'd0, elem_reset}, 32'd1);
    chk("mid_rst_wb_valid",   {31'd0, wb_valid},   32'd0);
    chk("mid_rst_busy",       {31'd0, busy},       32'd0);
    exp_q.delete();
    repeat (2) step();
    reset    = 1'b1;
    lat_cfg  = 1;
    wb_ready = 1'b1;
    repeat (4) step();
    chk("post_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("post_mid_busy",     {31'd0, busy},     32'd0);
    chk("post_mid_wb_data",  wb_data,           32'd0);
    chk("post_mid_issue_rdy", {31'd0, issue_ready}, 32'd1);

    // Stage still works after the mid-op reset
    do_issue(5'd12, 32'h1234_5678, 1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
